// File: rtl/lifo_stack.sv
// Synchronous LIFO stack: push on top, pop returns the most recent word on a
// registered output. Occupancy flags are registered alongside the count.
module lifo_stack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned ADDR_WIDTH = PTR_WIDTH - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  count;
  logic [PTR_WIDTH-1:0]  count_next;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  do_pop;
  logic                  do_write;

  // Decide the operation: a pop on a non-empty stack wins (and turns a
  // simultaneous push into a top replace); otherwise push if there is room.
  always_comb begin
    top_addr   = ADDR_WIDTH'(count - PTR_WIDTH'(1));
    wr_addr    = ADDR_WIDTH'(count);
    do_pop     = pop && !empty;
    do_write   = 1'b0;
    count_next = count;
    if (do_pop) begin
      if (push) begin
        do_write = 1'b1;
        wr_addr  = top_addr;
      end else begin
        count_next = count - PTR_WIDTH'(1);
      end
    end else if (push && !full) begin
      do_write   = 1'b1;
      count_next = count + PTR_WIDTH'(1);
    end
  end

  // Occupancy, flags and the registered pop word; reset wins over requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      pop_data <= '0;
    end else begin
      count <= count_next;
      empty <= (count_next == PTR_WIDTH'(0));
      full  <= (count_next == PTR_WIDTH'(DEPTH));
      if (do_pop) begin
        pop_data <= mem[top_addr];
      end
    end
  end

  // Storage is not cleared by reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_addr] <= push_data;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack with a reference stack model and a
// scoreboard queue of expected post-edge outputs.
module tb_lifo_stack;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [DW-1:0] pd;
    logic          em;
    logic          fu;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          empty;
  logic          full;

  logic [DW-1:0] model[$];
  logic [DW-1:0] model_pd;
  exp_t          sb[$];
  int            n_cmp;
  int            n_err;

  lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict via the model, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic p,
                      input logic [DW-1:0] d, input logic q);
    exp_t e;
    reset = r; push = p; push_data = d; pop = q;
    if (r) begin
      model.delete();
      model_pd = '0;
    end else if (q && model.size() > 0) begin
      model_pd = model[model.size()-1];
      if (p) model[model.size()-1] = d;
      else void'(model.pop_back());
    end else if (p && model.size() < DEPTH) begin
      model.push_back(d);
    end
    e.pd = model_pd;
    e.em = (model.size() == 0);
    e.fu = (model.size() == DEPTH);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pop_data"}, pop_data, e.pd);
    check({tag, ".empty"}, DW'(empty), DW'(e.em));
    check({tag, ".full"}, DW'(full), DW'(e.fu));
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    model_pd = '0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    @(posedge clk); #1;

    // 1. reset
    step("rst", 1'b1, 1'b0, 8'h00, 1'b0);
    check("rst.lit_pd", pop_data, 8'h00);

    // 2. push three, pop three
    step("p35", 1'b0, 1'b1, 8'h35, 1'b0);
    step("pA6", 1'b0, 1'b1, 8'hA6, 1'b0);
    step("p5A", 1'b0, 1'b1, 8'h5A, 1'b0);
    step("pop1", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop1.lit", pop_data, 8'h5A);
    step("hold", 1'b0, 1'b0, 8'h00, 1'b0);
    step("pop2", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop2.lit", pop_data, 8'hA6);
    step("pop3", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop3.lit", pop_data, 8'h35);

    // 3. pop on empty holds pop_data
    step("pop_empty", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop_empty.lit", pop_data, 8'h35);
    check("pop_empty.lit_em", DW'(empty), 8'h01);

    // push+pop on empty behaves as push only
    step("pp_empty", 1'b0, 1'b1, 8'h77, 1'b1);
    check("pp_empty.lit", pop_data, 8'h35);
    step("pop_77", 1'b0, 1'b0, 8'h00, 1'b1);

    // 4. fill, overflow attempt, replace at full, drain
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, DW'(i), 1'b0);
    check("fill.lit_full", DW'(full), 8'h01);
    step("push_full", 1'b0, 1'b1, 8'hFF, 1'b0);
    step("repl_full", 1'b0, 1'b1, 8'hEE, 1'b1);
    check("repl_full.lit", pop_data, 8'h0F);
    step("pop_EE", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop_EE.lit", pop_data, 8'hEE);
    for (int i = 0; i < DEPTH - 1; i++) step("drain", 1'b0, 1'b0, 8'h00, 1'b1);
    check("drain.lit", pop_data, 8'h00);
    check("drain.lit_em", DW'(empty), 8'h01);

    // 5. top replace keeps lower entries
    step("p11", 1'b0, 1'b1, 8'h11, 1'b0);
    step("p22", 1'b0, 1'b1, 8'h22, 1'b0);
    step("repl33", 1'b0, 1'b1, 8'h33, 1'b1);
    check("repl33.lit", pop_data, 8'h22);
    step("pop33", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop33.lit", pop_data, 8'h33);
    step("pop11", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop11.lit", pop_data, 8'h11);

    // 6. reset mid-sequence together with push
    step("q1", 1'b0, 1'b1, 8'hC1, 1'b0);
    step("q2", 1'b0, 1'b1, 8'hC2, 1'b0);
    step("q3", 1'b0, 1'b1, 8'hC3, 1'b0);
    step("rst_push", 1'b1, 1'b1, 8'hC4, 1'b0);
    check("rst_push.lit", pop_data, 8'h00);
    step("pop_after_rst", 1'b0, 1'b0, 8'h00, 1'b1);
    check("pop_after_rst.lit", pop_data, 8'h00);

    // mixed traffic against the model
    for (int i = 0; i < 60; i++)
      step("rand", 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
